// File: rtl/chess_pkg.sv
// Shared types and constants for the check sequencer: FSM state encoding,
// position field layout and the named piece indices.
package chess_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    IDLE   = 3'd1,
    BUILD  = 3'd2,
    FIRE   = 3'd3,
    WAIT   = 3'd4,
    RESULT = 3'd5
  } seq_state_t;

  // Each piece occupies one 6-bit field: row in the upper 3 bits, col in the lower 3.
  localparam int FIELD_W    = 6;
  localparam int ROW_OFS    = 3;
  localparam int COL_OFS    = 0;
  localparam int NUM_PIECES = 16;

  localparam logic [3:0] KING   = 4'd0;
  localparam logic [3:0] QUEEN  = 4'd1;
  localparam logic [3:0] ROOK_A = 4'd6;
  localparam logic [3:0] ROOK_H = 4'd7;

  // Pack a square into the field layout used by the location vectors.
  function automatic logic [FIELD_W-1:0] make_field(input logic [2:0] row, input logic [2:0] col);
    logic [FIELD_W-1:0] f;
    f = '0;
    f[ROW_OFS +: 3] = row;
    f[COL_OFS +: 3] = col;
    return f;
  endfunction

endpackage

// File: rtl/check_sequencer_trial_builder.sv
// Combinational trial-position builder: applies a candidate move to the held
// position, removes any captured opponent piece and flags moves that can be
// rejected without consulting the check unit.
module trial_builder
  import chess_pkg::*;
(
  input  logic [95:0] lvw,
  input  logic [95:0] lvb,
  input  logic [15:0] avw,
  input  logic [15:0] avb,
  input  logic        player,
  input  logic [3:0]  piece,
  input  logic [2:0]  row,
  input  logic [2:0]  col,
  output logic [95:0] trial_lvw,
  output logic [95:0] trial_lvb,
  output logic [15:0] trial_avw,
  output logic [15:0] trial_avb,
  output logic        reject
);

  logic [95:0]        own_lv;
  logic [95:0]        opp_lv;
  logic [15:0]        own_av;
  logic [15:0]        opp_av;
  logic [95:0]        new_own_lv;
  logic [15:0]        new_opp_av;
  logic [FIELD_W-1:0] dest;

  // Relocate the mover, clear captured opponents, detect dead mover / own-piece collision.
  always_comb begin
    own_lv     = player ? lvw : lvb;
    opp_lv     = player ? lvb : lvw;
    own_av     = player ? avw : avb;
    opp_av     = player ? avb : avw;
    dest       = make_field(row, col);
    reject     = !own_av[piece];
    new_own_lv = own_lv;
    new_opp_av = opp_av;
    new_own_lv[int'(piece)*FIELD_W +: FIELD_W] = dest;
    for (int k = 0; k < NUM_PIECES; k++) begin
      if (own_av[k] && (k != int'(piece)) && (own_lv[k*FIELD_W +: FIELD_W] == dest)) begin
        reject = 1'b1;
      end
      if (opp_av[k] && (opp_lv[k*FIELD_W +: FIELD_W] == dest)) begin
        new_opp_av[k] = 1'b0;
      end
    end
    trial_lvw = player ? new_own_lv : lvw;
    trial_lvb = player ? lvb : new_own_lv;
    trial_avw = player ? avw : new_opp_av;
    trial_avb = player ? new_opp_av : avb;
  end

endmodule

// File: rtl/check_sequencer.sv
// Move legality sequencer: holds the game position, accepts a candidate move,
// presents the resulting trial position to an external check unit, and
// commits the move only when no attacker gives check.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits for ready, and once raised valid and its
// payload stay unchanged until that transfer (or a load/reset abort).
module check_sequencer
  import chess_pkg::*;
#(
  parameter int CHECK_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [95:0] init_lvw,
  input  logic [95:0] init_lvb,
  input  logic [15:0] init_avw,
  input  logic [15:0] init_avb,
  input  logic        init_player,
  input  logic        mv_valid,
  output logic        mv_ready,
  input  logic [3:0]  mv_piece,
  input  logic [2:0]  mv_row,
  input  logic [2:0]  mv_col,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_legal,
  output logic [15:0] res_check,
  output logic        chk_enable,
  output logic        chk_player,
  output logic [95:0] chk_lvw,
  output logic [95:0] chk_lvb,
  output logic [15:0] chk_avw,
  output logic [15:0] chk_avb,
  input  logic [15:0] chk_is_check,
  output logic        turn,
  output logic [2:0]  fsm_state
);

  localparam logic [3:0] WAIT_LAST = 4'(CHECK_LATENCY - 1);

  seq_state_t  state;
  logic [95:0] hold_lvw;
  logic [95:0] hold_lvb;
  logic [15:0] hold_avw;
  logic [15:0] hold_avb;
  logic [3:0]  move_piece;
  logic [2:0]  move_row;
  logic [2:0]  move_col;
  logic [3:0]  wait_cnt;
  logic [95:0] trial_lvw;
  logic [95:0] trial_lvb;
  logic [15:0] trial_avw;
  logic [15:0] trial_avb;
  logic        reject;

  trial_builder u_trial (
    .lvw       (hold_lvw),
    .lvb       (hold_lvb),
    .avw       (hold_avw),
    .avb       (hold_avb),
    .player    (chk_player),
    .piece     (move_piece),
    .row       (move_row),
    .col       (move_col),
    .trial_lvw (trial_lvw),
    .trial_lvb (trial_lvb),
    .trial_avw (trial_avw),
    .trial_avb (trial_avb),
    .reject    (reject)
  );

  assign fsm_state = state;

  // Sequencer FSM with all outputs registered; load overrides any activity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      mv_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_legal  <= 1'b0;
      res_check  <= '0;
      chk_enable <= 1'b0;
      chk_player <= 1'b0;
      chk_lvw    <= '0;
      chk_lvb    <= '0;
      chk_avw    <= '0;
      chk_avb    <= '0;
      turn       <= 1'b1;
      hold_lvw   <= '0;
      hold_lvb   <= '0;
      hold_avw   <= '0;
      hold_avb   <= '0;
      move_piece <= '0;
      move_row   <= '0;
      move_col   <= '0;
      wait_cnt   <= '0;
    end else if (load) begin
      hold_lvw   <= init_lvw;
      hold_lvb   <= init_lvb;
      hold_avw   <= init_avw;
      hold_avb   <= init_avb;
      turn       <= init_player;
      state      <= IDLE;
      mv_ready   <= 1'b1;
      res_valid  <= 1'b0;
      chk_enable <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        EMPTY: ;
        IDLE: begin
          if (mv_valid) begin
            move_piece <= mv_piece;
            move_row   <= mv_row;
            move_col   <= mv_col;
            chk_player <= turn;
            mv_ready   <= 1'b0;
            state      <= BUILD;
          end
        end
        BUILD: begin
          chk_lvw <= trial_lvw;
          chk_lvb <= trial_lvb;
          chk_avw <= trial_avw;
          chk_avb <= trial_avb;
          if (reject) begin
            res_legal <= 1'b0;
            res_check <= '0;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            chk_enable <= 1'b1;
            state      <= FIRE;
          end
        end
        FIRE: begin
          chk_enable <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            res_check <= chk_is_check;
            res_legal <= (chk_is_check == 16'h0000);
            res_valid <= 1'b1;
            wait_cnt  <= '0;
            state     <= RESULT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            if (res_legal) begin
              hold_lvw <= chk_lvw;
              hold_lvb <= chk_lvb;
              hold_avw <= chk_avw;
              hold_avb <= chk_avb;
              turn     <= ~turn;
            end
            res_valid <= 1'b0;
            mv_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_check_sequencer.sv
// Bench for check_sequencer: a board-level model (per-side row/col/alive
// arrays) predicts verdicts, timing and trial positions; a per-cycle compare
// process checks the DUT against it, plus literal spot checks per scenario.
module tb_check_sequencer;
  import chess_pkg::*;

  localparam int L = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [95:0] init_lvw, init_lvb;
  logic [15:0] init_avw, init_avb;
  logic        init_player;
  logic        mv_valid, mv_ready;
  logic [3:0]  mv_piece;
  logic [2:0]  mv_row, mv_col;
  logic        res_valid, res_ready, res_legal;
  logic [15:0] res_check;
  logic        chk_enable, chk_player;
  logic [95:0] chk_lvw, chk_lvb;
  logic [15:0] chk_avw, chk_avb;
  logic [15:0] chk_is_check;
  logic        turn;
  logic [2:0]  fsm_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  check_sequencer #(.CHECK_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .load(load),
    .init_lvw(init_lvw), .init_lvb(init_lvb), .init_avw(init_avw), .init_avb(init_avb),
    .init_player(init_player),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_piece(mv_piece), .mv_row(mv_row), .mv_col(mv_col),
    .res_valid(res_valid), .res_ready(res_ready), .res_legal(res_legal), .res_check(res_check),
    .chk_enable(chk_enable), .chk_player(chk_player),
    .chk_lvw(chk_lvw), .chk_lvb(chk_lvb), .chk_avw(chk_avw), .chk_avb(chk_avb),
    .chk_is_check(chk_is_check), .turn(turn), .fsm_state(fsm_state)
  );

  // ---------------- model (side index 1 = white) ----------------
  logic [2:0] m_row [2][16];
  logic [2:0] m_col [2][16];
  logic       m_alive [2][16];
  logic [2:0] t_row [2][16];
  logic [2:0] t_col [2][16];
  logic       t_alive [2][16];
  logic [2:0] back [8] = '{3'd4, 3'd3, 3'd2, 3'd5, 3'd1, 3'd6, 3'd0, 3'd7};
  logic       m_turn;
  bit         m_loaded, pend, early, exp_legal, in_reset;
  int         hs_cyc, v_cyc, valid_cycles;
  logic [15:0] exp_check, m_chk, last_check;
  logic        last_legal;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [95:0] pack_lv(input bit use_trial, input int side);
    logic [95:0] v;
    v = '0;
    for (int k = 0; k < 16; k++)
      v[6*k +: 6] = use_trial ? {t_row[side][k], t_col[side][k]} : {m_row[side][k], m_col[side][k]};
    return v;
  endfunction

  function automatic logic [15:0] pack_av(input bit use_trial, input int side);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k] = use_trial ? t_alive[side][k] : m_alive[side][k];
    return v;
  endfunction

  // Standard opening: back rank pieces 0..7, pawns 8..15.
  task automatic set_initial();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16; k++) begin
        m_alive[s][k] = 1'b1;
        if (k < 8) begin
          m_row[s][k] = (s == 1) ? 3'd0 : 3'd7;
          m_col[s][k] = back[k];
        end else begin
          m_row[s][k] = (s == 1) ? 3'd1 : 3'd6;
          m_col[s][k] = 3'(k - 8);
        end
      end
    end
  endtask

  // Apply the move rules to the model board.
  task automatic build_model(input int p, input int r, input int c);
    int s = m_turn ? 1 : 0;
    int o = 1 - s;
    t_row = m_row;
    t_col = m_col;
    t_alive = m_alive;
    early = !m_alive[s][p];
    for (int k = 0; k < 16; k++) begin
      if (k != p && m_alive[s][k] && m_row[s][k] == 3'(r) && m_col[s][k] == 3'(c)) early = 1;
      if (m_alive[o][k] && m_row[o][k] == 3'(r) && m_col[o][k] == 3'(c)) t_alive[o][k] = 1'b0;
    end
    t_row[s][p] = 3'(r);
    t_col[s][p] = 3'(c);
  endtask

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic do_load(input bit player);
    set_initial();
    init_lvw = pack_lv(0, 1);
    init_lvb = pack_lv(0, 0);
    init_avw = pack_av(0, 1);
    init_avb = pack_av(0, 0);
    init_player = player;
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    mv_valid = 1'b0;
    m_turn = player;
    m_loaded = 1;
    pend = 0;
  endtask

  task automatic start_move(input int p, input int r, input int c, input logic [15:0] chk);
    mv_piece = 4'(p);
    mv_row = 3'(r);
    mv_col = 3'(c);
    mv_valid = 1'b1;
    @(posedge clock); #1;
    mv_valid = 1'b0;
    hs_cyc = cyc - 1;
    build_model(p, r, c);
    m_chk = chk;
    exp_check = early ? 16'h0 : chk;
    exp_legal = !early && (chk == 16'h0);
    v_cyc = hs_cyc + (early ? 2 : 3 + L);
    pend = 1;
  endtask

  task automatic finish_move(input int rwait);
    int guard = 0;
    valid_cycles = 0;
    while (pend && guard < 80) begin
      chk_is_check = (cyc == hs_cyc + 2 + L) ? m_chk : 16'hBEEF;
      res_ready = (cyc >= v_cyc + rwait);
      if (res_valid) valid_cycles++;
      if (res_ready) begin
        last_legal = res_legal;
        last_check = res_check;
      end
      @(posedge clock); #1;
      guard++;
      if (res_ready) begin
        if (exp_legal) begin
          m_row = t_row;
          m_col = t_col;
          m_alive = t_alive;
          m_turn = !m_turn;
        end
        pend = 0;
      end
    end
    res_ready = 1'b0;
    chk_is_check = 16'hBEEF;
    if (pend) begin
      n_vec++;
      n_err++;
      $display("FAIL move_timeout cycle %0d: got no result expected verdict by cycle %0d", cyc, v_cyc);
      pend = 0;
    end
  endtask

  task automatic do_move(input int p, input int r, input int c, input logic [15:0] chk, input int rwait);
    start_move(p, r, c, chk);
    finish_move(rwait);
  endtask

  task automatic check_reset_outputs();
    check("rst_state", 96'(fsm_state), 96'(EMPTY));
    check("rst_mv_ready", 96'(mv_ready), 96'(0));
    check("rst_res_valid", 96'(res_valid), 96'(0));
    check("rst_res_legal", 96'(res_legal), 96'(0));
    check("rst_res_check", 96'(res_check), 96'(0));
    check("rst_chk_enable", 96'(chk_enable), 96'(0));
    check("rst_turn", 96'(turn), 96'(1));
    check("rst_chk_lvw", chk_lvw, 96'(0));
    check("rst_chk_lvb", chk_lvb, 96'(0));
    check("rst_chk_av", 96'({chk_avw, chk_avb}), 96'(0));
    check("rst_chk_player", 96'(chk_player), 96'(0));
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clock) begin : cmp
    bit exp_v, exp_fire;
    if (!in_reset && m_loaded) begin
      exp_v = pend && (cyc >= v_cyc);
      exp_fire = pend && !early && (cyc == hs_cyc + 2);
      check("mv_ready", 96'(mv_ready), 96'(!pend));
      check("res_valid", 96'(res_valid), 96'(exp_v));
      check("chk_enable", 96'(chk_enable), 96'(exp_fire));
      check("turn", 96'(turn), 96'(m_turn));
      if (exp_v) begin
        check("res_legal", 96'(res_legal), 96'(exp_legal));
        check("res_check", 96'(res_check), 96'(exp_check));
      end
      if (pend && !early && cyc >= hs_cyc + 2 && cyc <= hs_cyc + 2 + L) begin
        check("chk_player", 96'(chk_player), 96'(m_turn));
        check("chk_lvw", chk_lvw, pack_lv(1, 1));
        check("chk_lvb", chk_lvb, pack_lv(1, 0));
        check("chk_avw", 96'(chk_avw), 96'(pack_av(1, 1)));
        check("chk_avb", 96'(chk_avb), 96'(pack_av(1, 0)));
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b0; load = 1'b0; init_lvw = '0; init_lvb = '0; init_avw = '0; init_avb = '0;
    init_player = 1'b0; mv_valid = 1'b0; mv_piece = '0; mv_row = '0; mv_col = '0;
    res_ready = 1'b0; chk_is_check = 16'hBEEF;
    in_reset = 1; m_loaded = 0; pend = 0; m_turn = 1'b1;
    repeat (2) @(posedge clock); #1;
    check_reset_outputs();
    reset = 1'b1;
    in_reset = 0;
    @(posedge clock); #1;
    check("empty_ready", 96'(mv_ready), 96'(0));
    check("empty_state", 96'(fsm_state), 96'(EMPTY));

    do_load(1'b1);
    check("load_state", 96'(fsm_state), 96'(IDLE));

    // White rook onto own pawn: early reject two cycles after the handshake.
    start_move(6, 1, 0, 16'h0);
    @(negedge clock);
    check("rej_build_valid", 96'(res_valid), 96'(0));
    @(posedge clock); #1;
    @(negedge clock);
    check("rej_valid", 96'(res_valid), 96'(1));
    check("rej_legal", 96'(res_legal), 96'(0));
    finish_move(0);

    // White queen to d4 (3,3), no check: committed, turn passes to black.
    do_move(1, 3, 3, 16'h0, 0);
    check("q_legal", 96'(last_legal), 96'(1));
    check("q_turn", 96'(turn), 96'(0));

    // Black pawn 8 to (5,0); held white queen field is 011_011.
    start_move(8, 5, 0, 16'h0);
    @(posedge clock); #1;
    check("q_field", 96'(chk_lvw[11:6]), 96'(6'b011011));
    check("b8_fire", 96'(chk_enable), 96'(1));
    finish_move(0);

    // White bishop 2 captures black knight 5 on (7,6).
    start_move(2, 7, 6, 16'h0);
    @(posedge clock); #1;
    check("cap_avb5", 96'(chk_avb[5]), 96'(0));
    finish_move(0);

    // Captured black knight tries to move: dead mover rejected.
    do_move(5, 5, 5, 16'h0, 0);
    check("dead_legal", 96'(last_legal), 96'(0));
    check("dead_check", 96'(last_check), 96'(0));

    // Black pawn 9 move that exposes check from attacker 8.
    start_move(9, 5, 1, 16'h0100);
    @(posedge clock); #1;
    check("held_avb5", 96'(chk_avb[5]), 96'(0));
    finish_move(0);
    check("chk_legal", 96'(last_legal), 96'(0));
    check("chk_value", 96'(last_check), 96'(16'h0100));
    check("chk_turn", 96'(turn), 96'(0));

    // Legal black move with res_ready withheld for 5 cycles.
    do_move(9, 4, 1, 16'h0, 5);
    check("stall_cycles", 96'(valid_cycles), 96'(6));
    check("stall_turn", 96'(turn), 96'(1));

    // Load during WAIT aborts the move.
    start_move(4, 2, 2, 16'h0);
    repeat (2) begin @(posedge clock); #1; end
    do_load(1'b0);
    check("abort_state", 96'(fsm_state), 96'(IDLE));
    check("abort_turn", 96'(turn), 96'(0));
    repeat (4) begin @(posedge clock); #1; end

    // Load and move handshake in the same cycle: load wins.
    mv_piece = 4'd12; mv_row = 3'd3; mv_col = 3'd4; mv_valid = 1'b1;
    do_load(1'b1);
    check("lm_state", 96'(fsm_state), 96'(IDLE));
    repeat (3) begin @(posedge clock); #1; end
    check("lm_turn", 96'(turn), 96'(1));

    // Reset asserted during FIRE.
    start_move(1, 2, 3, 16'h0);
    @(posedge clock); #1;
    check("pre_rst_fire", 96'(chk_enable), 96'(1));
    reset = 1'b0;
    in_reset = 1;
    pend = 0;
    m_loaded = 0;
    m_turn = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    in_reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("post_rst_no_fire", 96'(chk_enable), 96'(0));
      check("post_rst_ready", 96'(mv_ready), 96'(0));
    end
    @(posedge clock); #1;

    // Recovery: reload and play a legal pawn move.
    do_load(1'b1);
    do_move(12, 3, 4, 16'h0, 1);
    check("final_legal", 96'(last_legal), 96'(1));
    check("final_turn", 96'(turn), 96'(0));
    repeat (2) begin @(posedge clock); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/check_sequencer.md
CHECK_SEQUENCER -- requirements
Module: check_sequencer

Interface
REQ-001 SHALL have parameter CHECK_LATENCY, default 2: cycles from the chk_enable rising edge until chk_is_check is valid; legal range 1..15.
REQ-002 SHALL have port clock, in, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-004 SHALL have port load, in, 1: one-cycle pulse that captures the init_* position and init_player.
REQ-005 SHALL have ports init_lvw/init_lvb (in, 96), init_avw/init_avb (in, 16) and init_player (in, 1): the position to load.
REQ-006 SHALL have ports mv_valid (in, 1), mv_ready (out, 1), mv_piece (in, 4), mv_row (in, 3) and mv_col (in, 3): a candidate move by the side to move.
REQ-007 SHALL have ports res_valid (out, 1), res_ready (in, 1), res_legal (out, 1) and res_check (out, 16): the move verdict.
REQ-008 SHALL have ports chk_enable (out, 1) and chk_player (out, 1): drive the check unit.
REQ-009 SHALL have ports chk_lvw/chk_lvb (out, 96) and chk_avw/chk_avb (out, 16): the trial position presented to the check unit.
REQ-010 SHALL have port chk_is_check, in, 16: per-attacker check flags returned by the check unit.
REQ-011 SHALL have port turn, out, 1: side to move; 1 = white.

Function
REQ-012 SHALL store the held position with piece k at bits [6k+5:6k] of each location vector: row in [6k+5:6k+3], col in [6k+2:6k].
REQ-013 SHALL implement FSM states EMPTY, IDLE, BUILD, FIRE, WAIT and RESULT.
REQ-014 EMPTY: mv_ready = 0; load moves the FSM to IDLE.
REQ-015 IDLE: mv_ready = 1; the mv_valid && mv_ready handshake latches the move and moves the FSM to BUILD.
REQ-016 BUILD, one cycle: the trial position is the held position with the mover's field replaced by {mv_row, mv_col}.
REQ-017 BUILD: any alive opponent piece on the destination SHALL have its alive bit cleared in the trial position (capture).
REQ-018 BUILD: a dead mover or an own alive piece on the destination SHALL go directly to RESULT with res_legal = 0 and res_check = 0, skipping FIRE.
REQ-019 FIRE: chk_enable = 1 for exactly one cycle, with the chk_* vectors stable from BUILD until the FSM leaves WAIT.
REQ-020 WAIT: a 4-bit counter SHALL count CHECK_LATENCY cycles and then sample chk_is_check into res_check.
REQ-021 RESULT: res_legal = (res_check == 0).
REQ-022 RESULT: res_valid SHALL stay high, with res_* stable, until res_ready is high.
REQ-023 On the res_valid && res_ready handshake with res_legal = 1: the trial position SHALL be committed to the held position and turn toggled, both on that clock edge.
REQ-024 On the res_valid && res_ready handshake with res_legal = 0: the held position and turn SHALL be unchanged.
REQ-025 The FSM SHALL return to IDLE on the res_valid && res_ready handshake.
REQ-026 Verdict latency SHALL be 3 + CHECK_LATENCY cycles from the move handshake to res_valid; an early-rejected move (REQ-018) SHALL take 2 cycles.
REQ-027 load in any state other than EMPTY SHALL abort the operation in progress, drop res_valid, reload the position and go to IDLE.
REQ-028 When load and the move handshake occur in the same cycle, load SHALL win and the move SHALL be discarded.
REQ-029 chk_player SHALL equal turn as latched at the move handshake.

Reset
REQ-030 While reset is low: state = EMPTY, mv_ready = 0, res_valid = 0, res_legal = 0, res_check = 0, chk_enable = 0, turn = 1.
REQ-031 While reset is low: all position registers and chk_* vectors = 0 and the WAIT counter = 0.
REQ-032 Reset assertion mid-operation SHALL discard all state; release SHALL not produce a chk_enable pulse.

Structure
REQ-033 Package chess_pkg SHALL hold the FSM state enum, the 6-bit field width, the row/col field offsets and the piece index constants (KING = 0, QUEEN = 1, rooks 6/7).
REQ-034 Sub-module trial_builder SHALL be purely combinational: held position + move -> trial vectors plus an early-reject flag.

Verification
REQ-035 Scenario: load the initial position (white king row 0 col 4), move white queen (piece 1) to row 3 col 3 with chk_is_check = 0 -> res_legal = 1, turn toggles to 0, held white field 1 = 011_011.
REQ-036 Scenario: a move whose destination holds a white piece -> res_valid 2 cycles after the handshake, res_legal = 0, chk_enable never pulses.
REQ-037 Scenario: white piece 2 moves onto alive black piece 5's square, chk_is_check = 0 -> chk_avb bit 5 = 0 during FIRE; after commit, held avb bit 5 = 0.
REQ-038 Scenario: chk_is_check = 16'h0100 at sample time -> res_legal = 0, res_check = 16'h0100, held position and turn unchanged.
REQ-039 Scenario: res_ready held low 5 cycles -> res_valid and res_* stable throughout; commit occurs only on the ready cycle.
REQ-040 Scenario: load pulsed while in WAIT -> res_valid never rises and the FSM is in IDLE the next cycle; separately, reset asserted in FIRE -> all outputs reach their reset values immediately.
